sme_rng_pool: RTL and testbench

- Supplies the fresh guard randomness consumed by the masked DOM AND stage, i.e. the `rng` bus: RMAX words of N bits, RMAX = D+D*(D-1)/2.
- Built around a seeded xorshift64 generator filling two ping-pong banks; the consumer takes one complete bank per operation through a valid/take handshake.
- Guarantees no random word is ever presented for two operations, and flushes all stored randomness on reseed.

---
 rtl/sme_pkg.sv | 21 ++
 rtl/sme_rng_bank.sv | 57 +++++
 rtl/sme_rng_pool.sv | 118 +++++++++++
 tb/tb_sme_rng_pool.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared helpers for the SME masked datapath: share-count arithmetic and
// the xorshift64 generator step used by the guard-randomness pool.
package sme_pkg;

    // Zero is a fixed point of xorshift64, so a zero seed is replaced by this.
    localparam logic [63:0] SME_RNG_SEED_NZ = 64'h9E37_79B9_7F4A_7C15;

    function automatic int unsigned sme_rmax(input int unsigned d);
        return d + (d * (d - 1)) / 2;
    endfunction

    function automatic logic [63:0] sme_xs64_step(input logic [63:0] x);
        logic [63:0] t;
        t = x;
        t = t ^ (t << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

endpackage

// File: rtl/sme_rng_bank.sv
// One RMAX x N randomness bank: indexed write, full flag, and a clear that
// zeroes the contents so consumed words never linger in registers.
module sme_rng_bank
    import sme_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned RMAX = 6,
    parameter int unsigned CW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          wr_en,
    input  logic          set_full,
    input  logic [CW-1:0] wr_idx,
    input  logic [N-1:0]  wr_data,
    output logic          full,
    output logic [N-1:0]  data [RMAX-1:0]
);

    logic [N-1:0] data_q [RMAX-1:0];
    logic [N-1:0] data_d [RMAX-1:0];
    logic         full_q;
    logic         full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clr) begin
            for (int unsigned i = 0; i < RMAX; i++) begin
                data_d[i] = '0;
            end
            full_d = 1'b0;
        end else if (wr_en) begin
            data_d[wr_idx] = wr_data;
            if (set_full) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RMAX; i++) begin
                data_q[i] <= '0;
            end
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/sme_rng_pool.sv
// Guard-randomness pool: seeded xorshift64 filling two ping-pong banks,
// one complete bank handed to the consumer per take.
module sme_rng_pool
    import sme_pkg::*;
#(
    parameter int unsigned D = 3,
    parameter int unsigned N = 32
) (
    input  logic         g_clk,
    input  logic         g_reset,
    output logic         g_clk_req,
    input  logic         seed_valid,
    input  logic [63:0]  seed,
    input  logic         rng_take,
    output logic         rng_valid,
    output logic [N-1:0] rng [sme_rmax(D)-1:0]
);

    localparam int unsigned RMAX = sme_rmax(D);
    localparam int unsigned CW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    logic [63:0]   x_q, x_d;
    logic          seeded_q, seeded_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;

    logic          full0, full1;
    logic [N-1:0]  bank0 [RMAX-1:0];
    logic [N-1:0]  bank1 [RMAX-1:0];

    logic          fill, take, last;
    logic [63:0]   x_next;

    assign x_next    = sme_xs64_step(x_q);
    assign fill      = seeded_q && !(wr_sel_q ? full1 : full0) && !seed_valid;
    assign rng_valid = rd_sel_q ? full1 : full0;
    assign take      = rng_take && rng_valid && !seed_valid;
    assign last      = (count_q == CW'(RMAX - 1));

    always_comb begin
        x_d      = x_q;
        seeded_d = seeded_q;
        count_d  = count_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (seed_valid) begin
            x_d      = (seed == '0) ? SME_RNG_SEED_NZ : seed;
            seeded_d = 1'b1;
            count_d  = '0;
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
        end else begin
            if (fill) begin
                x_d = x_next;
                if (last) begin
                    count_d  = '0;
                    wr_sel_d = ~wr_sel_q;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            if (take) begin
                rd_sel_d = ~rd_sel_q;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            x_q      <= '0;
            seeded_q <= 1'b0;
            count_q  <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            seeded_q <= seeded_d;
            count_q  <= count_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // Take and fill never target the same bank: take needs it full, fill needs it not full.
    sme_rng_bank #(.N(N), .RMAX(RMAX), .CW(CW)) u_bank0 (
        .clk      (g_clk),
        .reset    (g_reset),
        .clr      (seed_valid || (take && !rd_sel_q)),
        .wr_en    (fill && !wr_sel_q),
        .set_full (last),
        .wr_idx   (count_q),
        .wr_data  (x_next[N-1:0]),
        .full     (full0),
        .data     (bank0)
    );

    sme_rng_bank #(.N(N), .RMAX(RMAX), .CW(CW)) u_bank1 (
        .clk      (g_clk),
        .reset    (g_reset),
        .clr      (seed_valid || (take && rd_sel_q)),
        .wr_en    (fill && wr_sel_q),
        .set_full (last),
        .wr_idx   (count_q),
        .wr_data  (x_next[N-1:0]),
        .full     (full1),
        .data     (bank1)
    );

    always_comb begin
        for (int unsigned i = 0; i < RMAX; i++) begin
            rng[i] = rd_sel_q ? bank1[i] : bank0[i];
        end
    end

    assign g_clk_req = (seeded_q && !(full0 && full1)) || (seed_valid && !g_reset);

endmodule

// File: tb/tb_sme_rng_pool.sv
// Directed bench for sme_rng_pool (D=3, N=32): latency, ordering, uniqueness,
// zero-seed substitution, reseed flush and mid-fill reset.
module tb_sme_rng_pool;

    localparam int unsigned RM = 6;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b0;
    logic        g_clk_req;
    logic        seed_valid = 1'b0;
    logic [63:0] seed = '0;
    logic        rng_take = 1'b0;
    logic        rng_valid;
    logic [31:0] rng [RM-1:0];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [63:0] mx;
    bit          seen [logic [31:0]];

    sme_rng_pool #(.D(3), .N(32)) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .g_clk_req  (g_clk_req),
        .seed_valid (seed_valid),
        .seed       (seed),
        .rng_take   (rng_take),
        .rng_valid  (rng_valid),
        .rng        (rng)
    );

    always #5 g_clk = ~g_clk;

    function automatic logic [63:0] xs(input logic [63:0] v);
        logic [63:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s check did not hold", tag);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < RM; i++) chk($sformatf("%s_w%0d", tag, i), 64'(rng[i]), 64'd0);
    endtask

    // Compares the presented bank with the next RM model words, in order.
    task automatic chk_bank(input string tag, input bit uniq);
        logic [31:0] w;
        for (int i = 0; i < RM; i++) begin
            mx = xs(mx);
            w  = mx[31:0];
            chk($sformatf("%s_w%0d", tag, i), 64'(rng[i]), 64'(w));
            if (uniq) begin
                chk($sformatf("%s_uniq%0d", tag, i), 64'(seen.exists(rng[i])), 64'd0);
                seen[rng[i]] = 1'b1;
            end
        end
    endtask

    initial begin
        // Reset, then idle unseeded with stray takes.
        g_reset = 1'b1;
        tick(); tick();
        g_reset = 1'b0;
        chk("rst_valid", 64'(rng_valid), 64'd0);
        chk("rst_clkreq", 64'(g_clk_req), 64'd0);
        chk_zero("rst_rng");
        for (int c = 0; c < 20; c++) begin
            rng_take = c[0];
            tick();
        end
        rng_take = 1'b0;
        chk("idle_valid", 64'(rng_valid), 64'd0);
        chk("idle_clkreq", 64'(g_clk_req), 64'd0);
        chk_zero("idle_rng");

        // Seed = 1 accepted at edge k.
        seed_valid = 1'b1; seed = 64'd1;
        tick();
        seed_valid = 1'b0;
        chk("s1_clkreq_k", 64'(g_clk_req), 64'd1);
        chk("s1_valid_k", 64'(rng_valid), 64'd0);
        repeat (5) tick();
        chk("s1_valid_k5", 64'(rng_valid), 64'd0);
        tick();
        chk("s1_valid_k6", 64'(rng_valid), 64'd1);
        chk("s1_w0_hand", 64'(rng[0]), 64'h4082_2041);
        chk("s1_w1_model", 64'(rng[1]), 64'(xs(64'h0000_0000_4082_2041) & 64'hFFFF_FFFF));
        repeat (5) tick();
        chk("s1_clkreq_k11", 64'(g_clk_req), 64'd1);
        tick();
        chk("s1_clkreq_k12", 64'(g_clk_req), 64'd0);
        chk("s1_valid_k12", 64'(rng_valid), 64'd1);

        // Sustained takes, one per RM cycles.
        mx = 64'd1;
        for (int op = 0; op < 50; op++) begin
            chk($sformatf("op%0d_valid", op), 64'(rng_valid), 64'd1);
            chk_bank($sformatf("op%0d", op), 1'b1);
            rng_take = 1'b1;
            tick();
            rng_take = 1'b0;
            repeat (RM - 1) tick();
        end

        // Zero seed is substituted.
        seed_valid = 1'b1; seed = 64'd0;
        tick();
        seed_valid = 1'b0;
        chk("s0_valid_k", 64'(rng_valid), 64'd0);
        repeat (RM) tick();
        chk("s0_valid", 64'(rng_valid), 64'd1);
        for (int i = 0; i < RM; i++) chk($sformatf("s0_nz%0d", i), 64'(rng[i] != 32'd0), 64'd1);
        mx = 64'h9E37_79B9_7F4A_7C15;
        chk_bank("s0", 1'b0);
        repeat (RM) tick();
        chk("s0_both_full_clkreq", 64'(g_clk_req), 64'd0);

        // Reseed with a simultaneous take while both banks are full.
        seed_valid = 1'b1; seed = 64'h0123_4567_89AB_CDEF; rng_take = 1'b1;
        tick();
        seed_valid = 1'b0; rng_take = 1'b0;
        chk("rs_valid_k", 64'(rng_valid), 64'd0);
        chk_zero("rs_flush");
        repeat (RM - 1) tick();
        chk("rs_valid_k5", 64'(rng_valid), 64'd0);
        tick();
        chk("rs_valid_k6", 64'(rng_valid), 64'd1);
        mx = 64'h0123_4567_89AB_CDEF;
        chk_bank("rs", 1'b0);

        // Reset mid-fill, after three words of the first bank.
        seed_valid = 1'b1; seed = 64'd5;
        tick();
        seed_valid = 1'b0;
        repeat (3) tick();
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        chk("mr_valid", 64'(rng_valid), 64'd0);
        chk("mr_clkreq", 64'(g_clk_req), 64'd0);
        chk_zero("mr_rng");
        repeat (20) tick();
        chk("mr_idle_valid", 64'(rng_valid), 64'd0);
        chk("mr_idle_clkreq", 64'(g_clk_req), 64'd0);
        chk_zero("mr_idle_rng");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end expected end before 200000");
        $fatal(1, "timeout");
    end

endmodule
